// File: rtl/uart_alu_frame_ctrl.sv
// rtl/uart_alu_frame_ctrl.sv - multi-byte UART frame assembler and result serialiser for the ALU
module uart_alu_frame_ctrl #(
    parameter int DBIT        = 8,
    parameter int NB_DATA     = 16,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [DBIT-1:0]    i_rx_data_in,
    input  logic [NB_DATA-1:0] i_alu_data_in,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_data_out,
    output logic               o_busy,
    output logic               o_timeout_err
);

    localparam int NB_BYTES = NB_DATA / DBIT;
    localparam int IW       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_CALC,
        S_TX,
        S_WAIT
    } state_t;

    state_t             state;
    logic [IW-1:0]      byte_idx;
    logic [IW-1:0]      tx_idx;
    logic [TW-1:0]      to_cnt;
    logic [NB_DATA-1:0] result;
    logic [NB_DATA-1:0] result_next;
    logic               in_rx;
    logic               frame_started;
    logic               timeout_hit;

    assign result_next   = result >> DBIT;
    assign in_rx         = (state == S_A) || (state == S_B) || (state == S_OP);
    // A frame is only "in progress" once its first byte has landed.
    assign frame_started = (state != S_A) || (byte_idx != '0);
    assign timeout_hit   = (TIMEOUT_CYC != 0) && in_rx && frame_started && (to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_A;
            byte_idx      <= '0;
            tx_idx        <= '0;
            to_cnt        <= '0;
            result        <= '0;
            o_data_a      <= '0;
            o_data_b      <= '0;
            o_operation   <= '0;
            o_tx_start    <= 1'b0;
            o_data_out    <= '0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_tx_start    <= 1'b0;
            o_timeout_err <= 1'b0;
            if (in_rx) begin
                // An arriving byte wins over a coinciding timeout expiry.
                if (i_rx_done_tick) begin
                    to_cnt <= '0;
                    case (state)
                        S_A, S_B: begin
                            if (state == S_A)
                                o_data_a[byte_idx*DBIT +: DBIT] <= i_rx_data_in;
                            else
                                o_data_b[byte_idx*DBIT +: DBIT] <= i_rx_data_in;
                            if (byte_idx == LAST_IDX) begin
                                byte_idx <= '0;
                                state    <= (state == S_A) ? S_B : S_OP;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                        default: begin
                            o_operation <= i_rx_data_in[NB_OP-1:0];
                            o_busy      <= 1'b1;
                            state       <= S_CALC;
                        end
                    endcase
                end else if (timeout_hit) begin
                    state         <= S_A;
                    byte_idx      <= '0;
                    to_cnt        <= '0;
                    o_timeout_err <= 1'b1;
                end else if (frame_started && (TIMEOUT_CYC != 0)) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                case (state)
                    S_CALC: begin
                        result     <= i_alu_data_in;
                        o_data_out <= i_alu_data_in[DBIT-1:0];
                        o_tx_start <= 1'b1;
                        tx_idx     <= '0;
                        state      <= S_TX;
                    end
                    S_TX: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_tx_done_tick) begin
                            result <= result_next;
                            if (tx_idx == LAST_IDX) begin
                                byte_idx <= '0;
                                o_busy   <= 1'b0;
                                state    <= S_A;
                            end else begin
                                tx_idx     <= tx_idx + 1'b1;
                                o_data_out <= result_next[DBIT-1:0];
                                o_tx_start <= 1'b1;
                                state      <= S_TX;
                            end
                        end
                    end
                    default: begin
                        state <= S_A;
                    end
                endcase
            end
        end
    end

endmodule
